hwpe_stream_addressgen_ctrl: RTL and testbench

Sequencing controller for one `hwpe_stream_addressgen` instance and its TCDM request port. On a start command it clears the address generator and issues exactly `trans_size_i` memory requests. It advances the generator once per granted request and bounds in-flight requests to `MAX_OUTSTANDING`. It reports completion only after every response has returned. The block sits between the engine FSM (start/done) and the address generator / TCDM master port.

---
 rtl/hwpe_stream_addressgen_ctrl.sv | 179 +++++++++++++++++
 tb/tb_hwpe_stream_addressgen_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_stream_addressgen_ctrl.sv
// ----------------------------------------------------------------------------
// hwpe_stream_addressgen_ctrl
//
// Sequencing controller for one address generator and its TCDM request port.
// On a start command it clears the generator, then issues exactly trans_size_i
// requests. It advances the generator once per granted request and keeps at
// most MAX_OUTSTANDING granted requests waiting for a response. Completion is
// reported only after every response has returned.
//
// Ports
//   clk_i, rst_ni     clock, synchronous active-low reset
//   clear_i           synchronous soft clear (same effect as reset)
//   start_i           start command, sampled in IDLE only
//   trans_size_i      number of requests, latched on an accepted start
//   stall_i           consumer backpressure; blocks new requests while high
//   busy_o            high in CLEAR, ISSUE and DRAIN
//   done_o            one-cycle completion pulse
//   err_o             sticky: a response arrived with nothing outstanding
//   ag_clear_o        address-generator clear
//   ag_enable_o       address-generator advance (one pulse per handshake)
//   tcdm_req_o        TCDM request
//   tcdm_gnt_i        TCDM grant
//   tcdm_r_valid_i    TCDM response valid
// ----------------------------------------------------------------------------
module hwpe_stream_addressgen_ctrl #(
    parameter int unsigned CNT             = 16,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           clear_i,
    input  logic           start_i,
    input  logic [CNT-1:0] trans_size_i,
    input  logic           stall_i,
    output logic           busy_o,
    output logic           done_o,
    output logic           err_o,
    output logic           ag_clear_o,
    output logic           ag_enable_o,
    output logic           tcdm_req_o,
    input  logic           tcdm_gnt_i,
    input  logic           tcdm_r_valid_i
);

    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    // The drop counter is one bit wider: a clear can convert a full set of
    // outstanding requests into drops while older drops are still pending.
    localparam int unsigned DW = OW + 1;

    localparam logic [OW-1:0] MAX_OUT  = OW'(MAX_OUTSTANDING);
    localparam logic [DW-1:0] DROP_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_e;

    state_e         state_q,  state_d;
    logic [CNT-1:0] size_q,   size_d;
    logic [CNT-1:0] issued_q, issued_d;
    logic [OW-1:0]  outst_q,  outst_d;
    logic           err_q,    err_d;
    // Responses still owed for requests abandoned by clear_i; they are
    // swallowed silently instead of being counted or flagged as errors.
    logic [DW-1:0]  drop_q,   drop_d;

    logic           handshake;
    logic           rsp_drop;
    logic           rsp_take;
    logic           rsp_spur;
    logic [DW:0]    drop_sum;

    // Request is decoded from registered state plus stall only; the grant
    // never feeds back into it.
    assign tcdm_req_o  = (state_q == ST_ISSUE) && !stall_i &&
                         (outst_q < MAX_OUT) && (issued_q < size_q);
    assign handshake   = tcdm_req_o & tcdm_gnt_i;
    assign ag_enable_o = handshake;

    // Responses arrive in order, so abandoned requests answer first.
    assign rsp_drop = tcdm_r_valid_i && (drop_q != '0);
    assign rsp_take = tcdm_r_valid_i && (drop_q == '0) && (outst_q != '0);
    assign rsp_spur = tcdm_r_valid_i && (drop_q == '0) && (outst_q == '0);

    assign busy_o     = (state_q == ST_CLEAR) || (state_q == ST_ISSUE) ||
                        (state_q == ST_DRAIN);
    assign done_o     = (state_q == ST_DONE);
    assign ag_clear_o = (state_q == ST_CLEAR);
    assign err_o      = err_q;

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path leaves a latch.
        state_d  = state_q;
        size_d   = size_q;
        issued_d = issued_q;
        outst_d  = outst_q;
        err_d    = err_q | rsp_spur;
        drop_d   = drop_q;
        drop_sum = '0;

        if (rsp_drop) begin
            drop_d = drop_q - DW'(1);
        end

        if (handshake && !rsp_take) begin
            outst_d = outst_q + OW'(1);
        end else if (!handshake && rsp_take) begin
            outst_d = outst_q - OW'(1);
        end

        if (handshake) begin
            issued_d = issued_q + CNT'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (trans_size_i != '0) begin
                        size_d   = trans_size_i;
                        issued_d = '0;
                        state_d  = ST_CLEAR;
                    end else begin
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_CLEAR: state_d = ST_ISSUE;
            ST_ISSUE: begin
                if (handshake && (issued_d == size_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            // Uses the post-update count so the last response's edge ends DRAIN.
            ST_DRAIN: begin
                if (outst_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (clear_i) begin
            state_d  = ST_IDLE;
            size_d   = '0;
            issued_d = '0;
            outst_d  = '0;
            err_d    = 1'b0;
            // Everything still in flight (including a grant this very cycle)
            // becomes a pending drop; saturate rather than wrap.
            drop_sum = {1'b0, drop_d} + {{(DW + 1 - OW){1'b0}}, outst_q + OW'(handshake && !rsp_take)}
                       - {{DW{1'b0}}, (!handshake && rsp_take)};
            drop_d   = drop_sum[DW] ? DROP_MAX : drop_sum[DW-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            size_q   <= '0;
            issued_q <= '0;
            outst_q  <= '0;
            err_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            size_q   <= size_d;
            issued_q <= issued_d;
            outst_q  <= outst_d;
            err_q    <= err_d;
            drop_q   <= drop_d;
        end
    end

endmodule

// File: tb/tb_hwpe_stream_addressgen_ctrl.sv
module tb_hwpe_stream_addressgen_ctrl;

    localparam int CNT  = 16;
    localparam int MAXO = 4;

    localparam int P_IDLE  = 0;
    localparam int P_CLEAR = 1;
    localparam int P_ISSUE = 2;
    localparam int P_DRAIN = 3;
    localparam int P_DONE  = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           clear;
    logic           start;
    logic [CNT-1:0] trans_size;
    logic           stall;
    logic           busy_o, done_o, err_o, ag_clear_o, ag_enable_o, tcdm_req_o;
    logic           gnt;
    logic           r_valid;

    hwpe_stream_addressgen_ctrl #(
        .CNT             (CNT),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clear_i        (clear),
        .start_i        (start),
        .trans_size_i   (trans_size),
        .stall_i        (stall),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o),
        .ag_clear_o     (ag_clear_o),
        .ag_enable_o    (ag_enable_o),
        .tcdm_req_o     (tcdm_req_o),
        .tcdm_gnt_i     (gnt),
        .tcdm_r_valid_i (r_valid)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // In-flight memory requests are kept as a queue of transfer tags; a clear
    // starts a new tag so older responses no longer count for this transfer.
    int  m_phase, m_size, m_issued, m_id;
    bit  m_err, m_last_hs;
    int  q[$];

    // Per-transfer observations taken from the DUT pins.
    int  cyc, en_cnt, done_cnt, agc_cnt, busy_cnt, last_en_cyc, last_done_cyc;
    int  obs_out, max_out, pend_at_done, en_early, k_since_start;
    bit  done_seen;
    string scen;

    function automatic int inflight();
        int n = 0;
        foreach (q[i]) if (q[i] == m_id) n++;
        return n;
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_size = 0; m_issued = 0; m_err = 1'b0;
        m_last_hs = 1'b0;
        q.delete();
    endtask

    task automatic clear_stats();
        en_cnt = 0; done_cnt = 0; agc_cnt = 0; busy_cnt = 0;
        last_en_cyc = -1; last_done_cyc = -1; obs_out = 0; max_out = 0;
        pend_at_done = -1; en_early = 0; done_seen = 1'b0; k_since_start = 0;
    endtask

    // One clock cycle: drive, sample mid-cycle, compare, advance the model.
    task automatic run_cycle(input bit rn, input bit cl, input bit st, input int sz,
                             input bit sl, input bit g, input bit rv);
        bit exp_req;
        logic [5:0] exp_v, act_v;
        rst_n = rn; clear = cl; start = st; trans_size = CNT'(sz);
        stall = sl; gnt = g; r_valid = rv;
        #4;
        exp_req = (m_phase == P_ISSUE) && !sl && (inflight() < MAXO) && (m_issued < m_size);
        exp_v = {(m_phase >= P_CLEAR && m_phase <= P_DRAIN), (m_phase == P_DONE), m_err,
                 (m_phase == P_CLEAR), exp_req, exp_req && g};
        act_v = {busy_o, done_o, err_o, ag_clear_o, tcdm_req_o, ag_enable_o};
        check($sformatf("%s cyc%0d busy/done/err/agc/req/age", scen, cyc), 32'(act_v), 32'(exp_v));

        if (rv && obs_out > 0) obs_out--;
        if (ag_enable_o === 1'b1) begin
            obs_out++; en_cnt++; last_en_cyc = cyc;
            if (k_since_start <= 10) en_early++;
        end
        if (obs_out > max_out) max_out = obs_out;
        if (done_o === 1'b1) begin
            done_cnt++; done_seen = 1'b1; last_done_cyc = cyc; pend_at_done = obs_out;
        end
        if (ag_clear_o === 1'b1) agc_cnt++;
        if (busy_o === 1'b1) busy_cnt++;

        if (!rn) begin
            model_reset();
        end else begin
            m_last_hs = exp_req && g;
            if (rv) begin
                if (q.size() == 0) m_err = 1'b1;
                else void'(q.pop_front());
            end
            if (m_last_hs) begin q.push_back(m_id); m_issued++; end
            if (cl) begin
                m_phase = P_IDLE; m_err = 1'b0; m_size = 0; m_issued = 0; m_id++;
            end else begin
                case (m_phase)
                    P_IDLE:  if (st) begin
                                 if (sz != 0) begin m_size = sz; m_issued = 0; m_phase = P_CLEAR; end
                                 else m_phase = P_DONE;
                             end
                    P_CLEAR: m_phase = P_ISSUE;
                    P_ISSUE: if (m_last_hs && m_issued == m_size) m_phase = P_DRAIN;
                    P_DRAIN: if (inflight() == 0) m_phase = P_DONE;
                    default: m_phase = P_IDLE;
                endcase
            end
        end
        cyc++;
        k_since_start++;
        @(posedge clk);
        #1;
    endtask

    // mode 0: grant always, response one cycle after each grant
    // mode 1: grant always, responses withheld for 10 cycles after start
    // mode 2: random grant/stall, random responses while any are pending
    task automatic run_xfer(input int sz, input int mode, input int limit);
        bit g, sl, rv;
        int k = 0;
        clear_stats();
        run_cycle(1, 0, 1, sz, 0, 0, 0);
        while (!done_seen && k < limit) begin
            g = 1'b1; sl = 1'b0; rv = 1'b0;
            case (mode)
                0: rv = m_last_hs;
                1: rv = (k_since_start > 10) && (q.size() > 0);
                default: begin
                    g  = 1'($urandom_range(0, 1));
                    sl = ($urandom_range(0, 3) == 0);
                    rv = (q.size() > 0) && ($urandom_range(0, 1) == 1);
                end
            endcase
            run_cycle(1, 0, 0, 0, sl, g, rv);
            k++;
        end
        check($sformatf("%s done_seen", scen), 32'(done_seen), 32'd1);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         rn, cl, st;
        logic [15:0] sz;
        bit         sl, g, rv;
        logic [5:0] exp;   // {busy, done, err, ag_clear, req, ag_enable}
    } vec_t;

    vec_t tbl[18];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 6'b000000}; // zero-size start
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 16'd3, 1'b0, 1'b0, 1'b0, 6'b010000}; // DONE, start ignored
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 6'b000000};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 16'd2, 1'b0, 1'b0, 1'b0, 6'b000000}; // start size 2
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 6'b100100}; // CLEAR
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 6'b100011}; // grant 1
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 6'b100000}; // stalled
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 6'b100011}; // grant 2 + rsp 1
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 6'b100000}; // DRAIN
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 6'b100000}; // last rsp
        tbl[10] = '{1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 6'b010000}; // DONE
        tbl[11] = '{1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 6'b000000}; // spurious rsp
        tbl[12] = '{1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 6'b001000}; // err sticky
        tbl[13] = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 6'b001000}; // reset edge
        tbl[14] = '{1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 6'b000000};
        tbl[15] = '{1'b1, 1'b0, 1'b1, 16'd1, 1'b0, 1'b0, 1'b0, 6'b000000}; // start size 1
        tbl[16] = '{1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 6'b100100}; // clear in CLEAR
        tbl[17] = '{1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 6'b000000};

        m_id = 0; cyc = 0;
        model_reset();
        clear_stats();
        rst_n = 1'b0; clear = 1'b0; start = 1'b0; trans_size = '0;
        stall = 1'b0; gnt = 1'b0; r_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        scen = "reset";
        run_cycle(1, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 18; i++) begin
            rst_n = tbl[i].rn; clear = tbl[i].cl; start = tbl[i].st; trans_size = tbl[i].sz;
            stall = tbl[i].sl; gnt = tbl[i].g; r_valid = tbl[i].rv;
            #4;
            check($sformatf("table row %0d", i),
                  32'({busy_o, done_o, err_o, ag_clear_o, tcdm_req_o, ag_enable_o}),
                  32'(tbl[i].exp));
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        model_reset();

        scen = "basic";
        run_xfer(5, 0, 100);
        check("basic grants", 32'(en_cnt), 32'd5);
        check("basic max outstanding", 32'(max_out), 32'd1);
        check("basic done latency", 32'(last_done_cyc - last_en_cyc), 32'd2);
        check("basic err", 32'(err_o), 32'd0);

        scen = "credit";
        run_xfer(8, 1, 200);
        check("credit early grants", 32'(en_early), 32'd4);
        check("credit grants", 32'(en_cnt), 32'd8);
        check("credit done pulses", 32'(done_cnt), 32'd1);

        scen = "stress";
        for (int it = 0; it < 6; it++) begin
            int sz;
            sz = (it == 0) ? 8 : int'($urandom_range(1, 20));
            run_xfer(sz, 2, 600);
            check($sformatf("stress%0d grants", it), 32'(en_cnt), 32'(sz));
            check($sformatf("stress%0d outst<=max", it), 32'(max_out <= MAXO), 32'd1);
            check($sformatf("stress%0d pending at done", it), 32'(pend_at_done), 32'd0);
        end

        scen = "zero";
        clear_stats();
        run_cycle(1, 0, 1, 0, 0, 0, 0);
        run_cycle(1, 0, 0, 0, 0, 0, 0);
        run_cycle(1, 0, 0, 0, 0, 0, 0);
        check("zero done pulses", 32'(done_cnt), 32'd1);
        check("zero ag_clear", 32'(agc_cnt), 32'd0);
        check("zero busy", 32'(busy_cnt), 32'd0);

        scen = "clearmid";
        clear_stats();
        run_cycle(1, 0, 1, 6, 0, 0, 0);
        run_cycle(1, 0, 0, 0, 0, 0, 0);
        run_cycle(1, 0, 0, 0, 0, 1, 0);
        run_cycle(1, 0, 0, 0, 0, 1, 1);
        run_cycle(1, 0, 0, 0, 0, 1, 0);
        check("clearmid grants before clear", 32'(en_cnt), 32'd3);
        run_cycle(1, 1, 0, 0, 0, 0, 0);
        run_cycle(1, 0, 0, 0, 0, 0, 1);
        run_cycle(1, 0, 0, 0, 0, 0, 1);
        run_cycle(1, 0, 0, 0, 0, 0, 0);
        check("clearmid err after stale rsps", 32'(err_o), 32'd0);
        run_xfer(3, 0, 100);
        check("clearmid restart grants", 32'(en_cnt), 32'd3);
        check("clearmid restart err", 32'(err_o), 32'd0);

        scen = "spurious";
        run_cycle(1, 0, 0, 0, 0, 0, 1);
        run_cycle(1, 0, 0, 0, 0, 0, 0);
        run_xfer(2, 0, 100);
        check("spurious err sticky", 32'(err_o), 32'd1);
        run_cycle(0, 0, 0, 0, 0, 0, 0);
        run_cycle(1, 0, 0, 0, 0, 0, 0);
        check("spurious err after reset", 32'(err_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
